// File: rtl/mpu_frame_parser.sv
// rtl/mpu_frame_parser.sv - MPU command payload parser: header decode, LOAD element writes, MULTIPLY start, error report
module mpu_frame_parser #(
    parameter  int VAR_SIZE    = 8,
    parameter  int MATRIX_SIZE = 10,
    localparam int IDX_W       = $clog2(MATRIX_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                rx_last,
    output logic                rx_ready,
    output logic                wr_en,
    output logic                wr_buf,
    output logic [IDX_W-1:0]    wr_row,
    output logic [IDX_W-1:0]    wr_col,
    output logic [VAR_SIZE-1:0] wr_data,
    output logic                load_done,
    output logic [IDX_W:0]      mat_rows,
    output logic [IDX_W:0]      mat_cols,
    output logic                mul_start,
    output logic [7:0]          mul_act,
    output logic [7:0]          mul_pool,
    input  logic                mul_busy,
    output logic                err_valid,
    output logic [2:0]          err_type
);
    localparam logic [7:0]       CMD_NONE     = 8'h00;
    localparam logic [7:0]       CMD_LOAD     = 8'h01;
    localparam logic [7:0]       CMD_MULTIPLY = 8'h02;
    localparam logic [2:0]       ERR_CMD      = 3'b010;
    localparam logic [2:0]       ERR_DIM      = 3'b011;
    localparam logic [2:0]       ERR_FRAME    = 3'b110;
    localparam logic [7:0]       MAX_DIM      = 8'(MATRIX_SIZE);
    localparam logic [IDX_W:0]   DIM_ONE      = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_MUL,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t              state_q;
    logic [2:0]          hdr_cnt_q;
    logic [7:0]          cmd_q;
    logic                buf_q;
    logic [IDX_W:0]      rows_q;
    logic [IDX_W:0]      cols_q;
    logic [7:0]          act_q;
    logic [7:0]          pool_q;
    logic                err_q;
    logic [2:0]          err_code_q;
    logic [IDX_W-1:0]    row_q;
    logic [IDX_W-1:0]    col_q;
    logic                done_pend_q;

    logic                rx_ready_q;
    logic                wr_en_q;
    logic                wr_buf_q;
    logic [IDX_W-1:0]    wr_row_q;
    logic [IDX_W-1:0]    wr_col_q;
    logic [VAR_SIZE-1:0] wr_data_q;
    logic                load_done_q;
    logic [IDX_W:0]      mat_rows_q;
    logic [IDX_W:0]      mat_cols_q;
    logic                mul_start_q;
    logic [7:0]          mul_act_q;
    logic [7:0]          mul_pool_q;
    logic                err_valid_q;
    logic [2:0]          err_type_q;

    logic                xfer;
    logic                dim_cmd;
    logic                last_col;
    logic                last_elem;
    logic                byte_bad;
    logic [2:0]          byte_code;
    logic                err_d;
    logic [2:0]          code_d;

    assign xfer      = rx_valid & rx_ready_q;
    assign dim_cmd   = (cmd_q == CMD_LOAD) || (cmd_q == CMD_MULTIPLY);
    assign last_col  = ({1'b0, col_q} == cols_q - DIM_ONE);
    assign last_elem = last_col && ({1'b0, row_q} == rows_q - DIM_ONE);

    // Content check of the header byte currently on the bus; an already latched error wins.
    always_comb begin
        byte_bad  = 1'b0;
        byte_code = ERR_CMD;
        case (hdr_cnt_q)
            3'd0: byte_bad = !(rx_data inside {CMD_NONE, CMD_LOAD, CMD_MULTIPLY});
            3'd1: byte_bad = (rx_data > 8'd1);
            3'd2, 3'd3: begin
                byte_bad  = dim_cmd && ((rx_data == 8'd0) || (rx_data > MAX_DIM));
                byte_code = ERR_DIM;
            end
            default: ;
        endcase
        err_d  = err_q | byte_bad;
        code_d = err_q ? err_code_q : byte_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR;
            hdr_cnt_q   <= '0;
            cmd_q       <= '0;
            buf_q       <= 1'b0;
            rows_q      <= '0;
            cols_q      <= '0;
            act_q       <= '0;
            pool_q      <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            done_pend_q <= 1'b0;
            rx_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_buf_q    <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            mat_rows_q  <= '0;
            mat_cols_q  <= '0;
            mul_start_q <= 1'b0;
            mul_act_q   <= '0;
            mul_pool_q  <= '0;
            err_valid_q <= 1'b0;
            err_type_q  <= '0;
        end else begin
            rx_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            done_pend_q <= 1'b0;
            load_done_q <= done_pend_q;
            mul_start_q <= 1'b0;
            err_valid_q <= 1'b0;
            if (done_pend_q) begin
                mat_rows_q <= rows_q;
                mat_cols_q <= cols_q;
            end
            case (state_q)
                S_HDR: begin
                    if (xfer) begin
                        case (hdr_cnt_q)
                            3'd0:    cmd_q  <= rx_data;
                            3'd1:    buf_q  <= rx_data[0];
                            3'd2:    rows_q <= rx_data[IDX_W:0];
                            3'd3:    cols_q <= rx_data[IDX_W:0];
                            3'd4:    act_q  <= rx_data;
                            default: pool_q <= rx_data;
                        endcase
                        if (byte_bad && !err_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= byte_code;
                        end
                        if (hdr_cnt_q != 3'd5) begin
                            if (rx_last) begin
                                hdr_cnt_q   <= '0;
                                state_q     <= S_REPORT;
                                rx_ready_q  <= 1'b0;
                                err_valid_q <= 1'b1;
                                err_type_q  <= err_d ? code_d : ERR_FRAME;
                            end else begin
                                hdr_cnt_q <= hdr_cnt_q + 3'd1;
                            end
                        end else begin
                            hdr_cnt_q <= '0;
                            if (err_d) begin
                                if (rx_last) begin
                                    state_q     <= S_REPORT;
                                    rx_ready_q  <= 1'b0;
                                    err_valid_q <= 1'b1;
                                    err_type_q  <= code_d;
                                end else begin
                                    state_q <= S_DRAIN;
                                end
                            end else if (cmd_q == CMD_NONE) begin
                                if (!rx_last) begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_FRAME;
                                    state_q    <= S_DRAIN;
                                end
                            end else if (cmd_q == CMD_MULTIPLY) begin
                                if (rx_last) begin
                                    state_q    <= S_MUL;
                                    rx_ready_q <= 1'b0;
                                end else begin
                                    err_q      <= 1'b1;
                                    err_code_q <= ERR_FRAME;
                                    state_q    <= S_DRAIN;
                                end
                            end else if (rx_last) begin
                                state_q     <= S_REPORT;
                                rx_ready_q  <= 1'b0;
                                err_valid_q <= 1'b1;
                                err_type_q  <= ERR_FRAME;
                            end else begin
                                state_q <= S_DATA;
                                row_q   <= '0;
                                col_q   <= '0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        wr_en_q   <= 1'b1;
                        wr_buf_q  <= buf_q;
                        wr_row_q  <= row_q;
                        wr_col_q  <= col_q;
                        wr_data_q <= rx_data[VAR_SIZE-1:0];
                        if (last_elem) begin
                            if (rx_last) begin
                                done_pend_q <= 1'b1;
                                state_q     <= S_HDR;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_FRAME;
                                state_q    <= S_DRAIN;
                            end
                        end else if (rx_last) begin
                            state_q     <= S_REPORT;
                            rx_ready_q  <= 1'b0;
                            err_valid_q <= 1'b1;
                            err_type_q  <= ERR_FRAME;
                        end else if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + IDX_ONE;
                        end else begin
                            col_q <= col_q + IDX_ONE;
                        end
                    end
                end
                S_MUL: begin
                    if (!mul_busy) begin
                        mul_start_q <= 1'b1;
                        mul_act_q   <= act_q;
                        mul_pool_q  <= pool_q;
                        mat_rows_q  <= rows_q;
                        mat_cols_q  <= cols_q;
                        state_q     <= S_HDR;
                    end else begin
                        rx_ready_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (xfer && rx_last) begin
                        state_q     <= S_REPORT;
                        rx_ready_q  <= 1'b0;
                        err_valid_q <= 1'b1;
                        err_type_q  <= err_code_q;
                    end
                end
                S_REPORT: begin
                    err_q   <= 1'b0;
                    state_q <= S_HDR;
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign rx_ready  = rx_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_buf    = wr_buf_q;
    assign wr_row    = wr_row_q;
    assign wr_col    = wr_col_q;
    assign wr_data   = wr_data_q;
    assign load_done = load_done_q;
    assign mat_rows  = mat_rows_q;
    assign mat_cols  = mat_cols_q;
    assign mul_start = mul_start_q;
    assign mul_act   = mul_act_q;
    assign mul_pool  = mul_pool_q;
    assign err_valid = err_valid_q;
    assign err_type  = err_type_q;

endmodule

// File: tb/tb_mpu_frame_parser.sv
// tb/tb_mpu_frame_parser.sv - directed and random frame checks of mpu_frame_parser against a frame-level model
module tb_mpu_frame_parser;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_last;
    logic       rx_ready;
    logic       wr_en;
    logic       wr_buf;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_data;
    logic       load_done;
    logic [4:0] mat_rows;
    logic [4:0] mat_cols;
    logic       mul_start;
    logic [7:0] mul_act;
    logic [7:0] mul_pool;
    logic       mul_busy;
    logic       err_valid;
    logic [2:0] err_type;

    always #5 clk = ~clk;

    mpu_frame_parser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_last   (rx_last),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_buf    (wr_buf),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .load_done (load_done),
        .mat_rows  (mat_rows),
        .mat_cols  (mat_cols),
        .mul_start (mul_start),
        .mul_act   (mul_act),
        .mul_pool  (mul_pool),
        .mul_busy  (mul_busy),
        .err_valid (err_valid),
        .err_type  (err_type)
    );

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;

    logic [7:0]  fr[$];
    logic [16:0] obs_wr[$],   exp_wr[$];
    logic [9:0]  obs_done[$], exp_done[$];
    logic [25:0] obs_mul[$],  exp_mul[$];
    logic [2:0]  obs_err[$],  exp_err[$];

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_wr.push_back({wr_buf, wr_row, wr_col, wr_data});
            last_wr_cyc = cycle;
        end
        if (load_done) begin
            obs_done.push_back({mat_rows, mat_cols});
            done_cyc = cycle;
        end
        if (mul_start) obs_mul.push_back({mul_act, mul_pool, mat_rows, mat_cols});
        if (err_valid) obs_err.push_back(err_type);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level outcome from the header/length rules, using plain arithmetic on the byte list.
    task automatic model_frame();
        int n;
        int lim;
        bit err;
        logic [2:0] code;
        int need;
        int got;
        n    = fr.size();
        lim  = (n < 6) ? n : 6;
        err  = 1'b0;
        code = 3'b000;
        for (int k = 0; k < lim; k++) begin
            if (!err) begin
                if (k == 0 && fr[0] > 8'd2) begin
                    err = 1'b1; code = 3'b010;
                end else if (k == 1 && fr[1] > 8'd1) begin
                    err = 1'b1; code = 3'b010;
                end else if ((k == 2 || k == 3) && (fr[0] == 8'd1 || fr[0] == 8'd2)
                             && (fr[k] == 8'd0 || fr[k] > 8'd10)) begin
                    err = 1'b1; code = 3'b011;
                end
            end
        end
        if (n < 6) begin
            exp_err.push_back(err ? code : 3'b110);
        end else if (err) begin
            exp_err.push_back(code);
        end else if (fr[0] == 8'd0) begin
            if (n != 6) exp_err.push_back(3'b110);
        end else if (fr[0] == 8'd2) begin
            if (n == 6) exp_mul.push_back({fr[4], fr[5], 5'(fr[2]), 5'(fr[3])});
            else        exp_err.push_back(3'b110);
        end else begin
            need = int'(fr[2]) * int'(fr[3]);
            got  = n - 6;
            if (got == 0) begin
                exp_err.push_back(3'b110);
            end else begin
                for (int i = 0; i < got && i < need; i++)
                    exp_wr.push_back({fr[1][0], 4'(i / int'(fr[3])), 4'(i % int'(fr[3])), fr[6+i]});
                if (got == need) exp_done.push_back({5'(fr[2]), 5'(fr[3])});
                else             exp_err.push_back(3'b110);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        rx_data  = d;
        rx_valid = 1'b1;
        rx_last  = l;
        for (int g = 0; g < 100 && !ok; g++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
        end
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL handshake byte=%0h observed_ready=%0b expected_ready=1", d, ok);
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], i == fr.size() - 1);
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".wr_n"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), 32'(obs_wr[i]), 32'(exp_wr[i]));
        chk({tag, ".done_n"}, 32'(obs_done.size()), 32'(exp_done.size()));
        for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
            chk($sformatf("%s.done%0d", tag, i), 32'(obs_done[i]), 32'(exp_done[i]));
        chk({tag, ".mul_n"}, 32'(obs_mul.size()), 32'(exp_mul.size()));
        for (int i = 0; i < obs_mul.size() && i < exp_mul.size(); i++)
            chk($sformatf("%s.mul%0d", tag, i), 32'(obs_mul[i]), 32'(exp_mul[i]));
        chk({tag, ".err_n"}, 32'(obs_err.size()), 32'(exp_err.size()));
        for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
            chk($sformatf("%s.err%0d", tag, i), 32'(obs_err[i]), 32'(exp_err[i]));
        obs_wr.delete();   exp_wr.delete();
        obs_done.delete(); exp_done.delete();
        obs_mul.delete();  exp_mul.delete();
        obs_err.delete();  exp_err.delete();
    endtask

    task automatic gen_header(input logic [7:0] cmd, input int r, input int c);
        fr.delete();
        fr.push_back(cmd);
        fr.push_back(8'($urandom_range(0, 1)));
        fr.push_back(8'(r));
        fr.push_back(8'(c));
        fr.push_back(8'($urandom));
        fr.push_back(8'($urandom));
    endtask

    task automatic gen_load(input int r, input int c);
        gen_header(8'd1, r, c);
        for (int i = 0; i < r * c; i++) fr.push_back(8'($urandom));
    endtask

    initial begin
        int kind;
        int mut;
        int len;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        mul_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.rx_ready",  32'(rx_ready),  32'd1);
        chk("reset.wr_en",     32'(wr_en),     32'd0);
        chk("reset.load_done", 32'(load_done), 32'd0);
        chk("reset.mul_start", 32'(mul_start), 32'd0);
        chk("reset.err_valid", 32'(err_valid), 32'd0);
        chk("reset.mat_dims",  32'({mat_rows, mat_cols}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fr = '{8'h01, 8'h00, 8'h02, 8'h03, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        model_frame();
        send_frame();
        idle();
        chk("load2x3.done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
        chk("load2x3.mat_rows", 32'(mat_rows), 32'd2);
        chk("load2x3.mat_cols", 32'(mat_cols), 32'd3);
        compare_all("load2x3");

        mul_busy = 1'b1;
        fr = '{8'h02, 8'h00, 8'h0A, 8'h0A, 8'h01, 8'h01};
        model_frame();
        send_frame();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("mul_busy.rx_ready%0d", i), 32'(rx_ready), 32'd0);
            chk($sformatf("mul_busy.no_start%0d", i), 32'(mul_start), 32'd0);
            @(posedge clk);
            #1;
        end
        mul_busy = 1'b0;
        idle();
        chk("mul.rx_ready_after", 32'(rx_ready), 32'd1);
        compare_all("mul");

        fr = '{8'h07, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        model_frame(); send_frame(); idle(); compare_all("bad_cmd");
        fr = '{8'h01, 8'h01, 8'h0B, 8'h02, 8'h00, 8'h00, 8'h55, 8'h66};
        model_frame(); send_frame(); idle(); compare_all("dim_big");
        fr = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00};
        model_frame(); send_frame(); idle(); compare_all("dim_zero");
        fr = '{8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        model_frame(); send_frame(); idle(); compare_all("trunc_load");
        fr = '{8'h01, 8'h00, 8'h02, 8'h02};
        model_frame(); send_frame(); idle(); compare_all("short_hdr");
        fr = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07};
        model_frame(); send_frame(); idle(); compare_all("long_load");
        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(); send_frame(); idle(); compare_all("none_ok");
        fr = '{8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00};
        model_frame(); send_frame(); idle(); compare_all("load_no_data");

        for (int grp = 0; grp < 4; grp++) begin
            for (int f = 0; f < 8; f++) begin
                kind = $urandom_range(0, 7);
                if (kind <= 2) begin
                    gen_load($urandom_range(1, 10), $urandom_range(1, 10));
                end else if (kind == 3) begin
                    gen_header(8'd2, $urandom_range(1, 10), $urandom_range(1, 10));
                end else if (kind == 4) begin
                    gen_header(8'd0, $urandom_range(0, 255), $urandom_range(0, 255));
                end else begin
                    gen_load($urandom_range(1, 4), $urandom_range(1, 4));
                    mut = $urandom_range(0, 4);
                    case (mut)
                        0: fr[0] = 8'($urandom_range(3, 255));
                        1: fr[1] = 8'($urandom_range(2, 255));
                        2: fr[$urandom_range(2, 3)] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(11, 255));
                        3: begin
                            len = $urandom_range(1, fr.size() - 1);
                            while (fr.size() > len) void'(fr.pop_back());
                        end
                        default: for (int e = 0; e < $urandom_range(1, 3); e++) fr.push_back(8'($urandom));
                    endcase
                end
                model_frame();
                send_frame();
            end
            idle();
            compare_all($sformatf("rand%0d", grp));
        end

        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h40 + i), 1'b0);
            exp_wr.push_back({1'b1, 4'(i / 3), 4'(i % 3), 8'(8'h40 + i)});
        end
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.mat_rows", 32'(mat_rows), 32'd0);
        chk("rst_mid.rx_ready", 32'(rx_ready), 32'd1);
        idle();
        compare_all("rst_mid");
        fr = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h00, 8'h00, 8'hA5, 8'h5A};
        model_frame(); send_frame(); idle(); compare_all("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
